// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
// Pure declarations: no logic, no latency, no flow control.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } pll_sup_state_t;

  localparam int unsigned RELOCK_W = 8;

  // One counter is shared by every timed state, so it must hold the largest terminal count.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clkin domain.
// Latency: 2 clkin edges; no backpressure.
module sync_2ff (
  input  logic clkin,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clkin) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives rPLL RESET, qualifies LOCK, and releases system reset once lock is stable.
// Lock path latency: 2 edges synchronizer + 1 edge FSM; no backpressure.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RESET_PULSE_CYCLES  = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic                lock_i,
  output logic                pll_reset_o,
  output logic                sys_reset_o,
  output logic                ready_o,
  output logic                fail_o,
  output logic [RELOCK_W-1:0] relock_count_o
);

  localparam int unsigned CNT_W   = cnt_width(RESET_PULSE_CYCLES, LOCK_STABLE_CYCLES,
                                              LOCK_TIMEOUT_CYCLES);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  logic lock_s;

  pll_sup_state_t      state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RETRY_W-1:0]  retries_q, retries_d, retries_inc;
  logic [RELOCK_W-1:0] relock_d;

  sync_2ff u_lock_sync (
    .clkin (clkin),
    .reset (reset),
    .d     (lock_i),
    .q     (lock_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retries_d   = retries_q;
    retries_inc = retries_q + RETRY_W'(1);
    relock_d    = relock_count_o;

    case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Lock wins over a coincident timeout.
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          retries_d = retries_inc;
          cnt_d     = '0;
          state_d   = (retries_inc == RETRY_LIMIT) ? FAIL : PLL_RST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // A dropout restarts the lock wait but does not spend a retry.
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d   = RUN;
          cnt_d     = '0;
          retries_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RUN: begin
        if (!lock_s) begin
          state_d = PLL_RST;
          cnt_d   = '0;
          if (relock_count_o != {RELOCK_W{1'b1}}) begin
            relock_d = relock_count_o + RELOCK_W'(1);
          end
        end
      end

      FAIL: begin
        state_d = FAIL;
      end

      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they switch on the same edge as the state.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q        <= PLL_RST;
      cnt_q          <= '0;
      retries_q      <= '0;
      relock_count_o <= '0;
      pll_reset_o    <= 1'b1;
      sys_reset_o    <= 1'b1;
      ready_o        <= 1'b0;
      fail_o         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retries_q      <= retries_d;
      relock_count_o <= relock_d;
      pll_reset_o    <= (state_d == PLL_RST);
      sys_reset_o    <= (state_d != RUN);
      ready_o        <= (state_d == RUN);
      fail_o         <= (state_d == FAIL);
    end
  end

endmodule
